// File: rtl/phase_timer_if.sv
// Handshake and status bundle between the light FSM and the phase timer.
// Combinational bundle, no latency of its own.
// No backpressure: the FSM holds start_req until fb acknowledges it.
interface phase_timer_if #(
  parameter int CW = 5
);
  logic          start_req;
  logic          hold;
  logic          disp_sel;
  logic          fb;
  logic          t_short;
  logic          t_long;
  logic          tick;
  logic          busy;
  logic [CW-1:0] elapsed;
  logic [CW-1:0] remain;

  // Light FSM side
  modport master (
    output start_req, hold, disp_sel,
    input  fb, t_short, t_long, tick, busy, elapsed, remain
  );

  // Timer side
  modport slave (
    input  start_req, hold, disp_sel,
    output fb, t_short, t_long, tick, busy, elapsed, remain
  );
endinterface

// File: rtl/phase_timer_ctrl.sv
// Shared 1 Hz phase timer: restarts on start_req, counts seconds, flags short/long intervals.
// fb one cycle after start_req; elapsed==k from LOAD cycle + k*DIV + 1.
// hold freezes the prescaler in RUN; start_req beats a coincident tick.
module phase_timer_ctrl #(
  parameter int DIV     = 50_000_000,
  parameter int SHORT_S = 3,
  parameter int LONG_S  = 30,
  parameter int CW      = 5,
  parameter int PW      = 26
) (
  input  logic          clk,
  input  logic          rst,
  phase_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_RUN     = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  localparam logic [CW-1:0] SHORT_C   = CW'(SHORT_S);
  localparam logic [CW-1:0] LONG_C    = CW'(LONG_S);
  localparam logic [PW-1:0] PRESC_TOP = PW'(DIV - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [CW-1:0] elapsed_q, elapsed_nxt;
  logic [CW-1:0] elapsed_inc;
  logic          t_short_q, t_short_nxt;
  logic          t_long_q, t_long_nxt;
  logic          tick_c;
  logic [CW-1:0] remain_base;

  assign elapsed_inc = elapsed_q + 1'b1;

  // State and counter registers; async active-low reset to quiescent values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      presc     <= '0;
      elapsed_q <= '0;
      t_short_q <= 1'b0;
      t_long_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      elapsed_q <= elapsed_nxt;
      t_short_q <= t_short_nxt;
      t_long_q  <= t_long_nxt;
    end
  end

  // Next-state and counter update; a pending start_req in RUN swallows the tick
  always_comb begin
    state_nxt   = state;
    presc_nxt   = presc;
    elapsed_nxt = elapsed_q;
    t_short_nxt = t_short_q;
    t_long_nxt  = t_long_q;
    tick_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start_req) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        presc_nxt   = '0;
        elapsed_nxt = '0;
        t_short_nxt = 1'b0;
        t_long_nxt  = 1'b0;
        state_nxt   = S_RUN;
      end
      S_RUN: begin
        if (bus.start_req) begin
          state_nxt = S_LOAD;
        end else if (!bus.hold) begin
          if (presc == PRESC_TOP) begin
            presc_nxt   = '0;
            tick_c      = 1'b1;
            elapsed_nxt = elapsed_inc;
            t_short_nxt = (elapsed_inc >= SHORT_C);
            t_long_nxt  = (elapsed_inc >= LONG_C);
            if (elapsed_inc >= LONG_C) state_nxt = S_EXPIRED;
          end else begin
            presc_nxt = presc + 1'b1;
          end
        end
      end
      S_EXPIRED: begin
        if (bus.start_req) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Display value: distance to the selected threshold, clamped at zero
  always_comb begin
    remain_base = bus.disp_sel ? SHORT_C : LONG_C;
    bus.remain  = (elapsed_q >= remain_base) ? '0 : (remain_base - elapsed_q);
  end

  assign bus.fb      = (state == S_LOAD);
  assign bus.busy    = (state == S_LOAD) || (state == S_RUN);
  assign bus.tick    = tick_c;
  assign bus.t_short = t_short_q;
  assign bus.t_long  = t_long_q;
  assign bus.elapsed = elapsed_q;

endmodule

// File: tb/tb_phase_timer_ctrl.sv
// Bench for phase_timer_ctrl: directed table, corner sequences, random traffic vs model.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Checks continue every cycle through the reference model.
module tb_phase_timer_ctrl;
  localparam int DIV = 4;
  localparam int SHORT_S = 3;
  localparam int LONG_S = 30;
  localparam int CW = 5;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tot = 0;
  int   n_bad = 0;
  int   cyc = 0;

  phase_timer_if #(.CW(CW)) bus ();

  phase_timer_ctrl #(
    .DIV(DIV), .SHORT_S(SHORT_S), .LONG_S(LONG_S), .CW(CW), .PW(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) next_cycle();
  endtask

  // Reference model: counts unheld RUN cycles since the last restart and
  // derives seconds by division; thresholds follow from the seconds count.
  int m_mode = 0;   // 0 idle, 1 load, 2 run, 3 expired
  int m_active = 0;
  int m_el = 0;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      m_mode   = 0;
      m_active = 0;
      m_el     = 0;
    end else begin
      int base;
      int e_rem;
      logic e_tick;
      base   = bus.disp_sel ? SHORT_S : LONG_S;
      e_rem  = (m_el >= base) ? 0 : base - m_el;
      e_tick = (m_mode == 2) && !bus.start_req && !bus.hold && ((m_active + 1) % DIV == 0);
      chk("m_fb", bus.fb, m_mode == 1);
      chk("m_busy", bus.busy, (m_mode == 1) || (m_mode == 2));
      chk("m_tick", bus.tick, e_tick);
      chk("m_elapsed", bus.elapsed, m_el);
      chk("m_t_short", bus.t_short, m_el >= SHORT_S);
      chk("m_t_long", bus.t_long, m_el >= LONG_S);
      chk("m_remain", bus.remain, e_rem);
      case (m_mode)
        0, 3: if (bus.start_req) m_mode = 1;
        1: begin
          m_mode = 2; m_active = 0; m_el = 0;
        end
        default: begin
          if (bus.start_req) m_mode = 1;
          else if (!bus.hold) begin
            m_active++;
            m_el = m_active / DIV;
            if (m_el >= LONG_S) m_mode = 3;
          end
        end
      endcase
    end
  end

  typedef struct {
    int   c;
    logic fb, busy, tick, ts, tl;
    int   el;
  } vec_t;
  vec_t tbl [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int f, f2;
    logic fb_prev;
    tbl[0]  = '{0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{2,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[3]  = '{5,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[4]  = '{6,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[5]  = '{9,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[6]  = '{13,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    tbl[7]  = '{14,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3};
    tbl[8]  = '{121, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 29};
    tbl[9]  = '{122, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 30};
    tbl[10] = '{126, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 30};

    bus.start_req = 1'b0;
    bus.hold      = 1'b0;
    bus.disp_sel  = 1'b0;

    // Reset values
    #3;
    chk("rst_fb", bus.fb, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tick", bus.tick, 0);
    chk("rst_t_short", bus.t_short, 0);
    chk("rst_t_long", bus.t_long, 0);
    chk("rst_elapsed", bus.elapsed, 0);
    chk("rst_remain_long", bus.remain, LONG_S);
    bus.disp_sel = 1'b1;
    #1;
    chk("rst_remain_short", bus.remain, SHORT_S);
    bus.disp_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    next_cycle();

    // Tests 1-2: first start, then run on to expiry
    cyc = 0;
    bus.start_req = 1'b1;
    for (int c = 0; c < 128; c++) begin
      if (c == 2) bus.start_req = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 11; k++) begin
        if (tbl[k].c == c) begin
          chk("tbl_fb", bus.fb, tbl[k].fb);
          chk("tbl_busy", bus.busy, tbl[k].busy);
          chk("tbl_tick", bus.tick, tbl[k].tick);
          chk("tbl_t_short", bus.t_short, tbl[k].ts);
          chk("tbl_t_long", bus.t_long, tbl[k].tl);
          chk("tbl_elapsed", bus.elapsed, tbl[k].el);
          chk("tbl_remain", bus.remain, LONG_S - tbl[k].el);
        end
      end
      next_cycle();
    end

    // Test 3: restart from EXPIRED, then restart coinciding with a tick at elapsed=7
    bus.start_req = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("t3_fb_from_expired", bus.fb, 1);
    f = cyc;
    next_cycle();
    bus.start_req = 1'b0;
    run_to(f + 32);
    bus.start_req = 1'b1;
    @(negedge clk);
    chk("t3_tick_suppressed", bus.tick, 0);
    chk("t3_elapsed_7", bus.elapsed, 7);
    next_cycle();
    @(negedge clk);
    chk("t3_fb", bus.fb, 1);
    f2 = cyc;
    next_cycle();
    bus.start_req = 1'b0;
    @(negedge clk);
    chk("t3_fb_single", bus.fb, 0);
    chk("t3_elapsed_clr", bus.elapsed, 0);
    chk("t3_t_short_clr", bus.t_short, 0);
    run_to(f2 + 12);
    @(negedge clk);
    chk("t3_t_short_early", bus.t_short, 0);
    next_cycle();
    @(negedge clk);
    chk("t3_t_short_rise", bus.t_short, 1);
    chk("t3_elapsed_3", bus.elapsed, 3);

    // Test 4: hold 10 cycles mid-second
    run_to(f2 + 14);
    for (int i = 0; i < 10; i++) begin
      bus.hold = 1'b1;
      @(negedge clk);
      chk("t4_no_tick_held", bus.tick, 0);
      chk("t4_elapsed_held", bus.elapsed, 3);
      next_cycle();
    end
    bus.hold = 1'b0;
    run_to(f2 + 25);
    @(negedge clk);
    chk("t4_no_tick_early", bus.tick, 0);
    next_cycle();
    @(negedge clk);
    chk("t4_tick_late", bus.tick, 1);
    next_cycle();
    @(negedge clk);
    chk("t4_elapsed_4", bus.elapsed, 4);

    // Test 5: display selection at elapsed=5
    run_to(f2 + 31);
    bus.disp_sel = 1'b1;
    @(negedge clk);
    chk("t5_elapsed_5", bus.elapsed, 5);
    chk("t5_remain_short", bus.remain, 0);
    next_cycle();
    bus.disp_sel = 1'b0;
    @(negedge clk);
    chk("t5_remain_long", bus.remain, 25);

    // Test 6: async reset mid-RUN at elapsed=12
    run_to(f2 + 59);
    @(negedge clk);
    chk("t6_elapsed_12", bus.elapsed, 12);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_fb", bus.fb, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_tick", bus.tick, 0);
    chk("t6_t_short", bus.t_short, 0);
    chk("t6_t_long", bus.t_long, 0);
    chk("t6_elapsed", bus.elapsed, 0);
    chk("t6_remain", bus.remain, LONG_S);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_idle_fb", bus.fb, 0);
      chk("t6_idle_busy", bus.busy, 0);
      next_cycle();
    end

    // Random traffic, checked by the model every cycle
    fb_prev = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.start_req && fb_prev) bus.start_req = 1'b0;
      else if (!bus.start_req && $urandom_range(0, 149) == 0) bus.start_req = 1'b1;
      bus.hold     = ($urandom_range(0, 5) == 0);
      bus.disp_sel = 1'($urandom_range(0, 1));
      @(negedge clk);
      fb_prev = bus.fb;
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
